// File: rtl/id_pkg.sv
// Shared decode definitions for the ID stage: instruction field positions
// and the constant-extension mode encoding.
package id_pkg;

  localparam int OP_HI   = 31;
  localparam int OP_LO   = 29;
  localparam int RF_HI   = 28;
  localparam int RA_HI   = 23;
  localparam int RB_HI   = 18;
  localparam int FUNC_HI = 1;

  // Register fields are 5 bits wide; narrower files use the low bits.
  localparam int RF_LO   = RF_HI - 4;
  localparam int RA_LO   = RA_HI - 4;
  localparam int RB_LO   = RB_HI - 4;
  localparam int FUNC_LO = FUNC_HI - 1;
  localparam int CONST_HI = RF_HI;

  typedef enum logic [1:0] {
    EXT_Z14 = 2'b00,
    EXT_S14 = 2'b01,
    EXT_Z19 = 2'b10,
    EXT_Z29 = 2'b11
  } ext_sel_t;

endpackage

// File: rtl/id_regfile.sv
// Two-read, one-write register file with register 0 hardwired to zero.
// Reads are combinational; the write lands on the rising clock edge.
module id_regfile #(
  parameter  int N    = 32,
  parameter  int REGS = 32,
  localparam int RW   = $clog2(REGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [RW-1:0] rw,
  input  logic [N-1:0]  wd,
  input  logic [RW-1:0] addr_a,
  input  logic [RW-1:0] addr_b,
  output logic [N-1:0]  rd_a,
  output logic [N-1:0]  rd_b
);

  logic [N-1:0] mem [REGS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REGS; i++) mem[i] <= '0;
    end else if (we && rw != '0) begin
      mem[rw] <= wd;
    end
  end

  assign rd_a = (addr_a == '0) ? '0 : mem[addr_a];
  assign rd_b = (addr_b == '0) ? '0 : mem[addr_b];

endmodule

// File: rtl/id_stage_pipe.sv
// Registered decode stage with ID/EX handshake, load-use bubbles, flush and
// a saturating stall counter. Define ID_WB_BYPASS_EN to forward same-cycle writeback.
module id_stage_pipe #(
  parameter  int N       = 32,
  parameter  int REGS    = 32,
  parameter  int STALL_W = 16,
  localparam int RW      = $clog2(REGS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       instruction,
  input  logic               rb_selector,
  input  logic [1:0]         ext_selector,
  input  logic               flush,
  input  logic               ex_load_pending,
  input  logic [RW-1:0]      ex_rf,
  input  logic               we,
  input  logic [RW-1:0]      rw,
  input  logic [N-1:0]       wd,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2:0]         op,
  output logic [1:0]         func,
  output logic [RW-1:0]      ra,
  output logic [RW-1:0]      rb,
  output logic [RW-1:0]      rf,
  output logic [N-1:0]       rda,
  output logic [N-1:0]       rdb,
  output logic [N-1:0]       extended,
  output logic [STALL_W-1:0] stall_cnt
);

  import id_pkg::*;

  logic [RW-1:0] ra_f, rb_f, rf_f, src_b;
  logic [N-1:0]  rf_rd_a, rf_rd_b, data_a, data_b, ext_val;
  logic          hazard, advance, accept;

  assign ra_f  = instruction[RA_LO +: RW];
  assign rb_f  = instruction[RB_LO +: RW];
  assign rf_f  = instruction[RF_LO +: RW];
  assign src_b = rb_selector ? rf_f : rb_f;

  id_regfile #(.N(N), .REGS(REGS)) u_regfile (
    .clk    (clk),
    .reset  (reset),
    .we     (we),
    .rw     (rw),
    .wd     (wd),
    .addr_a (ra_f),
    .addr_b (src_b),
    .rd_a   (rf_rd_a),
    .rd_b   (rf_rd_b)
  );

`ifdef ID_WB_BYPASS_EN
  assign data_a = (we && rw != '0 && rw == ra_f)  ? wd : rf_rd_a;
  assign data_b = (we && rw != '0 && rw == src_b) ? wd : rf_rd_b;
`else
  assign data_a = rf_rd_a;
  assign data_b = rf_rd_b;
`endif

  // A load in EX targeting one of our sources must land before we read it.
  assign hazard  = ex_load_pending && (ex_rf != '0) && in_valid &&
                   ((ra_f == ex_rf) || (src_b == ex_rf));
  assign advance = !out_valid || out_ready || flush;
  assign in_ready = flush || (!hazard && (!out_valid || out_ready));
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    ext_val = '0;
    case (ext_sel_t'(ext_selector))
      EXT_Z14: ext_val = {{(N-14){1'b0}}, instruction[13:0]};
      EXT_S14: ext_val = {{(N-14){instruction[13]}}, instruction[13:0]};
      EXT_Z19: ext_val = {{(N-19){1'b0}}, instruction[18:0]};
      EXT_Z29: ext_val = {{(N-CONST_HI-1){1'b0}}, instruction[CONST_HI:0]};
      default: ext_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      op        <= '0;
      func      <= '0;
      ra        <= '0;
      rb        <= '0;
      rf        <= '0;
      rda       <= '0;
      rdb       <= '0;
      extended  <= '0;
    end else begin
      if (advance) out_valid <= (flush || hazard) ? 1'b0 : in_valid;
      if (accept) begin
        op       <= instruction[OP_HI:OP_LO];
        func     <= instruction[FUNC_HI:FUNC_LO];
        ra       <= ra_f;
        rb       <= rb_f;
        rf       <= rf_f;
        rda      <= data_a;
        rdb      <= data_b;
        extended <= ext_val;
      end
    end
  end

  // Flush overrides a coincident hazard, so such cycles are not counted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (hazard && !flush && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Self-checking bench for id_stage_pipe: directed scenarios plus randomized
// traffic compared against a transaction-level reference model.
module tb_id_stage_pipe;

  localparam int N       = 32;
  localparam int REGS    = 32;
  localparam int STALL_W = 4;
  localparam int RW      = 5;
  localparam logic [STALL_W-1:0] STALL_MAX = 4'hF;

  logic               clk;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [N-1:0]       instruction;
  logic               rb_selector;
  logic [1:0]         ext_selector;
  logic               flush;
  logic               ex_load_pending;
  logic [RW-1:0]      ex_rf;
  logic               we;
  logic [RW-1:0]      rw;
  logic [N-1:0]       wd;
  logic               out_valid;
  logic               out_ready;
  logic [2:0]         op;
  logic [1:0]         func;
  logic [RW-1:0]      ra, rb, rf;
  logic [N-1:0]       rda, rdb, extended;
  logic [STALL_W-1:0] stall_cnt;

  int tests_run;
  int tests_failed;

  // Reference model state
  logic [31:0]        m_regs [32];
  logic               m_valid;
  logic [2:0]         m_op;
  logic [1:0]         m_func;
  logic [4:0]         m_ra, m_rb, m_rf;
  logic [31:0]        m_rda, m_rdb, m_ext;
  logic [STALL_W-1:0] m_stall;

  id_stage_pipe #(.N(N), .REGS(REGS), .STALL_W(STALL_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .instruction     (instruction),
    .rb_selector     (rb_selector),
    .ext_selector    (ext_selector),
    .flush           (flush),
    .ex_load_pending (ex_load_pending),
    .ex_rf           (ex_rf),
    .we              (we),
    .rw              (rw),
    .wd              (wd),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .op              (op),
    .func            (func),
    .ra              (ra),
    .rb              (rb),
    .rf              (rf),
    .rda             (rda),
    .rdb             (rdb),
    .extended        (extended),
    .stall_cnt       (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] mk_instr(logic [2:0] o, logic [4:0] f, logic [4:0] a,
                                           logic [4:0] b, logic [13:0] lo);
    return {o, f, a, b, lo};
  endfunction

  function automatic logic [31:0] ext_model(logic [31:0] iw, logic [1:0] sel);
    logic [31:0] c14 = iw & 32'h0000_3FFF;
    case (sel)
      2'd0: return c14;
      2'd1: return (c14 >= 32'h2000) ? c14 - 32'h4000 : c14;
      2'd2: return iw & 32'h0007_FFFF;
      default: return iw & 32'h1FFF_FFFF;
    endcase
  endfunction

  function automatic logic [31:0] read_model(logic [4:0] idx);
    if (idx == 5'd0) return 32'h0;
`ifdef ID_WB_BYPASS_EN
    if (we && rw != 5'd0 && rw == idx) return wd;
`endif
    return m_regs[idx];
  endfunction

  function automatic logic hazard_now();
    logic [4:0] a = instruction[23:19];
    logic [4:0] b = rb_selector ? instruction[28:24] : instruction[18:14];
    return ex_load_pending && ex_rf != 5'd0 && in_valid && (a == ex_rf || b == ex_rf);
  endfunction

  function automatic logic ready_now();
    return flush || (!hazard_now() && (!m_valid || out_ready));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_valid = 1'b0; m_op = '0; m_func = '0; m_ra = '0; m_rb = '0; m_rf = '0;
    m_rda = '0; m_rdb = '0; m_ext = '0; m_stall = '0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    logic        hz  = hazard_now();
    logic        rdy = ready_now();
    logic [31:0] iw  = instruction;
    if (!m_valid || out_ready || flush) m_valid = (flush || hz) ? 1'b0 : in_valid;
    if (in_valid && rdy && !flush) begin
      m_op   = iw[31:29];
      m_func = iw[1:0];
      m_ra   = iw[23:19];
      m_rb   = iw[18:14];
      m_rf   = iw[28:24];
      m_rda  = read_model(iw[23:19]);
      m_rdb  = read_model(rb_selector ? iw[28:24] : iw[18:14]);
      m_ext  = ext_model(iw, ext_selector);
    end
    if (hz && !flush && m_stall != STALL_MAX) m_stall = m_stall + 1'b1;
    if (we && rw != 5'd0) m_regs[rw] = wd;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; instruction = '0; rb_selector = 0; ext_selector = 0; flush = 0;
    ex_load_pending = 0; ex_rf = '0; we = 0; rw = '0; wd = '0; out_ready = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 0;
    model_reset();
    #12;
    tests_run++;
    if ({out_valid, stall_cnt, rda, rdb, extended} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: got valid=%b stall=%h rda=%h rdb=%h ext=%h expected all zero",
               out_valid, stall_cnt, rda, rdb, extended);
    end
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    @(negedge clk);
    reset = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic_decode();
    we = 1; rw = 5; wd = 32'h0000_00AA; tick();
    rw = 6; wd = 32'h0000_0055; tick();
    rw = 7; wd = 32'h0000_0077; tick();
    we = 0;
    in_valid = 1; instruction = mk_instr(3'b010, 5'd7, 5'd5, 5'd6, 14'h0002);
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL decode_in_ready: got %b expected 1", in_ready);
    end
    tick();
    rb_selector = 1;
    tests_run++;
    if ({out_valid, op, func, rf, rda, rdb} !== {1'b1, 3'b010, 2'b10, 5'd7, 32'hAA, 32'h55}) begin
      tests_failed++;
      $display("[TB] FAIL decode_fields: got v=%b op=%h func=%h rf=%h rda=%h rdb=%h expected v=1 op=2 func=2 rf=7 rda=aa rdb=55",
               out_valid, op, func, rf, rda, rdb);
    end
    tick();
    in_valid = 0; rb_selector = 0;
    tests_run++;
    if ({rb, rdb} !== {5'd6, 32'h77}) begin
      tests_failed++;
      $display("[TB] FAIL decode_rb_selector: got rb=%h rdb=%h expected rb=6 rdb=77", rb, rdb);
    end
    tick();
  endtask

  task automatic test_extension();
    logic [31:0] iws  [6] = '{32'h0000_2000, 32'h0000_2000, 32'h1FFF_FFFF,
                              32'h1FFF_FFFF, 32'h1FFF_FFFF, 32'h0000_1FFF};
    logic [1:0]  sels [6] = '{2'd1, 2'd0, 2'd3, 2'd2, 2'd0, 2'd1};
    logic [31:0] exps [6] = '{32'hFFFF_E000, 32'h0000_2000, 32'h1FFF_FFFF,
                              32'h0007_FFFF, 32'h0000_3FFF, 32'h0000_1FFF};
    for (int i = 0; i < 6; i++) begin
      in_valid = 1; instruction = iws[i]; ext_selector = sels[i];
      tick();
      tests_run++;
      if (extended !== exps[i]) begin
        tests_failed++;
        $display("[TB] FAIL extension_%0d: got %h expected %h", i, extended, exps[i]);
      end
    end
    in_valid = 0; ext_selector = 0;
    tick();
  endtask

  task automatic test_hazard();
    out_ready = 1; ex_load_pending = 1; ex_rf = 5;
    in_valid = 1; instruction = mk_instr(3'b001, 5'd1, 5'd5, 5'd2, 14'h0);
    #1;
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL hazard_ra_ready: got %b expected 0", in_ready);
    end
    tick();
    tests_run++;
    if ({out_valid, stall_cnt} !== {1'b0, 4'd1}) begin
      tests_failed++;
      $display("[TB] FAIL hazard_bubble: got v=%b stall=%0d expected v=0 stall=1", out_valid, stall_cnt);
    end
    rb_selector = 1; instruction = mk_instr(3'b001, 5'd5, 5'd3, 5'd2, 14'h0);
    tick();
    tests_run++;
    if ({out_valid, stall_cnt} !== {1'b0, 4'd2}) begin
      tests_failed++;
      $display("[TB] FAIL hazard_src_b: got v=%b stall=%0d expected v=0 stall=2", out_valid, stall_cnt);
    end
    rb_selector = 0; ex_rf = 0; instruction = mk_instr(3'b001, 5'd0, 5'd0, 5'd0, 14'h0);
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL hazard_x0_ignored: got in_ready=%b expected 1", in_ready);
    end
    ex_rf = 5; ex_load_pending = 0; instruction = mk_instr(3'b001, 5'd1, 5'd5, 5'd2, 14'h0);
    tick();
    in_valid = 0;
    tests_run++;
    if ({out_valid, rda, stall_cnt} !== {1'b1, 32'hAA, 4'd2}) begin
      tests_failed++;
      $display("[TB] FAIL hazard_release: got v=%b rda=%h stall=%0d expected v=1 rda=aa stall=2",
               out_valid, rda, stall_cnt);
    end
    ex_load_pending = 1; in_valid = 1; flush = 1;
    tick();
    flush = 0; in_valid = 0;
    tests_run++;
    if ({out_valid, stall_cnt} !== {1'b0, 4'd2}) begin
      tests_failed++;
      $display("[TB] FAIL flush_beats_hazard: got v=%b stall=%0d expected v=0 stall=2", out_valid, stall_cnt);
    end
    in_valid = 1;
    for (int i = 0; i < 20; i++) tick();
    in_valid = 0; ex_load_pending = 0;
    tests_run++;
    if (stall_cnt !== STALL_MAX) begin
      tests_failed++;
      $display("[TB] FAIL stall_saturate: got %0d expected %0d", stall_cnt, STALL_MAX);
    end
    tick();
  endtask

  task automatic test_backpressure_flush();
    out_ready = 1; in_valid = 1;
    instruction = mk_instr(3'b101, 5'd9, 5'd5, 5'd6, 14'h0123);
    tick();
    out_ready = 0; instruction = mk_instr(3'b011, 5'd1, 5'd6, 5'd5, 14'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if (in_ready !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL backpressure_ready_%0d: got %b expected 0", i, in_ready);
      end
      tick();
      tests_run++;
      if ({out_valid, op, rda, extended} !== {1'b1, 3'b101, 32'hAA, 32'h123}) begin
        tests_failed++;
        $display("[TB] FAIL backpressure_hold_%0d: got v=%b op=%h rda=%h ext=%h expected v=1 op=5 rda=aa ext=123",
                 i, out_valid, op, rda, extended);
      end
    end
    flush = 1;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL flush_ready: got %b expected 1", in_ready);
    end
    tick();
    flush = 0; in_valid = 0; out_ready = 1;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL flush_clears: got out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_collision();
    logic [31:0] exp_first;
`ifdef ID_WB_BYPASS_EN
    exp_first = 32'h1234;
`else
    exp_first = 32'hAA;
`endif
    in_valid = 1; instruction = mk_instr(3'b000, 5'd0, 5'd5, 5'd0, 14'h0);
    we = 1; rw = 5; wd = 32'h1234;
    tick();
    we = 0;
    tests_run++;
    if (rda !== exp_first) begin
      tests_failed++;
      $display("[TB] FAIL collision_same_cycle: got %h expected %h", rda, exp_first);
    end
    tick();
    tests_run++;
    if (rda !== 32'h1234) begin
      tests_failed++;
      $display("[TB] FAIL collision_next_cycle: got %h expected 1234", rda);
    end
    instruction = mk_instr(3'b000, 5'd0, 5'd0, 5'd0, 14'h0);
    we = 1; rw = 0; wd = 32'hFFFF;
    tick();
    we = 0;
    tests_run++;
    if (rda !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL x0_write_same_cycle: got %h expected 0", rda);
    end
    tick();
    in_valid = 0;
    tests_run++;
    if ({rda, rdb} !== 64'h0) begin
      tests_failed++;
      $display("[TB] FAIL x0_read: got rda=%h rdb=%h expected 0", rda, rdb);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid        = ($urandom % 4) != 0;
      instruction     = $urandom;
      rb_selector     = 1'($urandom);
      ext_selector    = 2'($urandom);
      flush           = ($urandom % 16) == 0;
      ex_load_pending = ($urandom % 3) == 0;
      ex_rf           = ($urandom % 2) ? instruction[23:19] : 5'($urandom);
      out_ready       = ($urandom % 3) != 0;
      we              = 1'($urandom);
      rw              = ($urandom % 2) ? instruction[23:19] : 5'($urandom);
      wd              = $urandom;
      #1;
      tests_run++;
      if (in_ready !== ready_now()) begin
        tests_failed++;
        $display("[TB] FAIL random_ready_%0d: got %b expected %b", i, in_ready, ready_now());
      end
      tick();
      tests_run++;
      if ({out_valid, stall_cnt, op, func, ra, rb, rf, rda, rdb, extended} !==
          {m_valid, m_stall, m_op, m_func, m_ra, m_rb, m_rf, m_rda, m_rdb, m_ext}) begin
        tests_failed++;
        $display("[TB] FAIL random_out_%0d: got v=%b st=%h op=%h f=%h ra=%h rb=%h rf=%h a=%h b=%h e=%h expected v=%b st=%h op=%h f=%h ra=%h rb=%h rf=%h a=%h b=%h e=%h",
                 i, out_valid, stall_cnt, op, func, ra, rb, rf, rda, rdb, extended,
                 m_valid, m_stall, m_op, m_func, m_ra, m_rb, m_rf, m_rda, m_rdb, m_ext);
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid_stall();
    in_valid = 1; instruction = mk_instr(3'b110, 5'd0, 5'd5, 5'd0, 14'h0);
    tick();
    out_ready = 0; ex_load_pending = 1; ex_rf = 5;
    tick();
    tests_run++;
    if ({out_valid, stall_cnt} !== {1'b1, m_stall}) begin
      tests_failed++;
      $display("[TB] FAIL stall_before_reset: got v=%b stall=%0d expected v=1 stall=%0d",
               out_valid, stall_cnt, m_stall);
    end
    #2;
    reset = 0;
    model_reset();
    #1;
    tests_run++;
    if ({out_valid, stall_cnt, rda} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL async_reset: got v=%b stall=%0d rda=%h expected all zero", out_valid, stall_cnt, rda);
    end
    idle_inputs();
    @(negedge clk);
    reset = 1;
    in_valid = 1; instruction = mk_instr(3'b000, 5'd0, 5'd5, 5'd0, 14'h0);
    tick();
    in_valid = 0;
    tests_run++;
    if ({out_valid, rda} !== {1'b1, 32'h0}) begin
      tests_failed++;
      $display("[TB] FAIL regs_cleared: got v=%b rda=%h expected v=1 rda=0", out_valid, rda);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_basic_decode();
    test_extension();
    test_hazard();
    test_backpressure_flush();
    test_collision();
    test_random();
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised, registered successor to the combinational decode stage.
- Decodes the instruction fields, reads two source registers from an internal 2R1W register file, and extends the constant field in one of four modes.
- Results go into an ID/EX output register with a valid/ready handshake on both sides.
- Detects load-use hazards against the EX stage, inserts bubbles, supports flush, and keeps a saturating stall counter.

Parameters:
- N, 32, datapath and instruction width (N >= 32)
- REGS, 32, register-file depth; address width RW = $clog2(REGS), must be <= 5
- STALL_W, 16, stall counter width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  instruction available from IF
- in_ready  out  1  ID accepts the instruction this cycle
- instruction  in  N  instruction word
- rb_selector  in  1  0: port B reads rb field; 1: port B reads rf field
- ext_selector  in  2  extension mode
- flush  in  1  discard the instruction being accepted and the ID/EX contents
- ex_load_pending  in  1  EX holds a load
- ex_rf  in  RW  destination register of the EX load
- we  in  1  writeback enable
- rw  in  RW  writeback register
- wd  in  N  writeback data
- out_valid  out  1  ID/EX register holds a valid decode
- out_ready  in  1  EX accepts the decode
- op  out  3  instruction[31:29]
- func  out  2  instruction[1:0]
- ra, rb, rf  out  RW  instruction[23:19], [18:14], [28:24] (low RW bits)
- rda, rdb  out  N  source data
- extended  out  N  extended constant
- stall_cnt  out  STALL_W  saturating count of hazard cycles

Behaviour:
- Reset (reset=0, asynchronous):
  - all outputs registered and cleared; out_valid=0; stall_cnt=0; all registers zero.
- Register file:
  - register 0 always reads 0; writes to register 0 are ignored.
  - write occurs on the clk edge when we=1.
  - reads are combinational from the decoded indices.
- Port B source index: src_b = rb_selector ? rf field : rb field.
- Hazard (all must hold):
  - ex_load_pending=1
  - ex_rf != 0
  - in_valid=1
  - ra field == ex_rf, or src_b == ex_rf
- in_ready = flush | (!hazard & (!out_valid | out_ready)).
- Output register advance (when !out_valid | out_ready | flush):
  - flush=1: out_valid<=0; input dropped (in_ready=1).
  - hazard: out_valid<=0 (bubble); input held upstream.
  - otherwise: out_valid<=in_valid, and all data fields load from the current decode.
  - Data fields load only when in_valid & in_ready & !flush; otherwise they hold.
- Stall: out_valid=1 & out_ready=0 & !flush → all outputs hold, in_ready=0.
- Latency: exactly 1 cycle from acceptance to out_valid.
- Extension, constant c = instruction[28:0]:
  - 00: zero-extend [13:0]
  - 01: sign-extend [13:0]
  - 10: zero-extend [18:0]
  - 11: zero-extend [28:0]
  - Upper bits above N are never truncated because N >= 32.
- Read/write collision: same-cycle we with rw equal to a source index reads the OLD value (unless the macro below is defined).
- stall_cnt increments each cycle hazard=1 and saturates at all-ones; it does not wrap.
- flush and hazard in the same cycle: flush wins, and no stall_cnt increment.

Optional Feature:
- Macro: ID_WB_BYPASS_EN.
- Defined: when we=1, rw!=0 and rw equals the ra field (or src_b), rda (or rdb) captures wd instead of the array value.
- Undefined: behaviour as above (old value); EX must tolerate the one-cycle write/read gap.

Decomposition:
- Package id_pkg:
  - field position localparams (OP_HI=31, OP_LO=29, RF_HI=28, RA_HI=23, RB_HI=18, FUNC_HI=1)
  - enum ext_sel_t {EXT_Z14, EXT_S14, EXT_Z19, EXT_Z29}
- Sub-module id_regfile #(N, REGS):
  - 2 async read ports, 1 sync write port, async active-low clear.

Test Plan:
- Reset, then write x5=0x0000_00AA and x6=0x0000_0055; decode op=3'b010, rf=7, ra=5, rb=6 → next cycle out_valid=1, rda=0xAA, rdb=0x55, rf=7.
- ext_selector=01 with instruction[13:0]=0x2000 → extended=0xFFFF_E000. Same word with 00 → 0x0000_2000. Instruction[28:0]=all-ones with 11 → 0x1FFF_FFFF.
- ex_load_pending=1, ex_rf=5, instruction reads ra=5 → in_ready=0, out_valid=0 next cycle, stall_cnt=1. Drop pending → instruction accepted, out_valid=1 one cycle later.
- out_ready=0 for 3 cycles with out_valid=1 → outputs stable, in_ready=0. Assert flush → out_valid=0 next cycle, in_ready=1.
- we=1, rw=5, wd=0x1234 in the same cycle as a read of ra=5:
  - without ID_WB_BYPASS_EN → rda = old value.
  - with ID_WB_BYPASS_EN → rda=0x1234.
- Write rw=0 with wd=0xFFFF → read ra=0 gives 0. Drive reset low mid-stall → out_valid=0 and stall_cnt=0 immediately.
